// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time, buffers it for decode.
// Optional ebreak halt is compiled in with IFU_EBREAK_HALT_EN.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
`ifdef IFU_EBREAK_HALT_EN
    ,
    HALT  = 2'd3
`endif
  } state_e;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] opc_q, opc_d;
  logic        fault_q, fault_d;
  logic        live_q;

  logic [31:0] redir_tgt;
  logic        req_fire;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};

  // Requests only go out once the cycle after reset release has begun.
  assign req_valid = live_q && (state_q == FETCH);
  assign req_addr  = pc_q;
  assign req_fire  = req_valid && req_ready;
  assign out_valid = (state_q == HOLD);
  assign out_inst  = inst_q;
  assign out_pc    = opc_q;
  assign out_fault = fault_q;
`ifdef IFU_EBREAK_HALT_EN
  assign halted    = (state_q == HALT);
`else
  assign halted    = 1'b0;
`endif

  // State, PC and output buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= 32'h0;
      opc_q   <= RESET_PC;
      fault_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      fault_q <= fault_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state logic; a redirect outranks every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    fault_d = fault_q;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = redir_tgt;
          if (req_fire) begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_tgt;
          if (rsp_valid) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            drop_d = 1'b1;
          end
        end else if (rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            inst_d  = rsp_err ? 32'h0 : rsp_data;
            fault_d = rsp_err;
            opc_d   = pc_q;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = FETCH;
        end else if (out_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
`ifdef IFU_EBREAK_HALT_EN
          if (inst_q == EBREAK) state_d = HALT;
`endif
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

`ifndef IFU_EBREAK_HALT_EN
  logic unused_ok;
  assign unused_ok = ^EBREAK;
`endif

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed bench for the fetch unit.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_ysyx_24100005_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int checks = 0;
  int failures = 0;

  ysyx_24100005_ifu dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .out_fault(out_fault),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fetch one word from FETCH state and leave the unit in HOLD.
  task automatic fetch(input string tag, input logic [31:0] addr,
                       input logic [31:0] data, input logic err);
    chk({tag, "_reqv"}, {31'd0, req_valid}, 32'd1);
    chk({tag, "_addr"}, req_addr, addr);
    chk({tag, "_ov0"}, {31'd0, out_valid}, 32'd0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk({tag, "_wait_reqv"}, {31'd0, req_valid}, 32'd0);
    chk({tag, "_wait_ov"}, {31'd0, out_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = data;
    rsp_err   = err;
    tick();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_inst"}, out_inst, err ? 32'h0 : data);
    chk({tag, "_pc"}, out_pc, addr);
    chk({tag, "_fault"}, {31'd0, out_fault}, {31'd0, err});
  endtask

  initial begin
    rst = 1'b1;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = 32'h0;
    rsp_err = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    chk("rst_reqv", {31'd0, req_valid}, 32'd0);
    chk("rst_addr", req_addr, 32'h8000_0000);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_opc", out_pc, 32'h8000_0000);
    chk("rst_fault", {31'd0, out_fault}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    rst = 1'b0;
    tick();

    // Back-to-back fetches at full rate.
    for (int i = 0; i < 3; i++) begin
      fetch("seq", 32'h8000_0000 + 32'(4 * i), 32'h0000_0013, 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // Downstream stall in HOLD.
    fetch("stall", 32'h8000_000C, 32'h00A0_0093, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ov", {31'd0, out_valid}, 32'd1);
      chk("stall_inst", out_inst, 32'h00A0_0093);
      chk("stall_pc", out_pc, 32'h8000_000C);
      chk("stall_reqv", {31'd0, req_valid}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_next", req_addr, 32'h8000_0010);

    // Redirect while waiting; stale response two cycles later.
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    chk("rw_reqv", {31'd0, req_valid}, 32'd0);
    tick();
    rsp_valid = 1'b1;
    rsp_data = 32'h1111_1111;
    tick();
    rsp_valid = 1'b0;
    chk("rw_ov", {31'd0, out_valid}, 32'd0);

    // Redirect in HOLD beats out_ready.
    fetch("rh", 32'h8000_0100, 32'h2222_2222, 1'b0);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    tick();
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("rh_ov", {31'd0, out_valid}, 32'd0);

    // Access fault, fetch continues.
    fetch("err", 32'h8000_0200, 32'hDEAD_BEEF, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    fetch("aft", 32'h8000_0204, 32'h0000_0033, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Redirect in FETCH without then with a handshake.
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0303;
    tick();
    chk("rf_reqv", {31'd0, req_valid}, 32'd1);
    chk("rf_addr", req_addr, 32'h8000_0300);
    req_ready = 1'b1;
    redirect_pc = 32'h8000_0400;
    tick();
    req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("rfh_reqv", {31'd0, req_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_data = 32'h3333_3333;
    tick();
    rsp_valid = 1'b0;
    chk("rfh_ov", {31'd0, out_valid}, 32'd0);

    // ebreak.
    fetch("ebk", 32'h8000_0400, 32'h0010_0073, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`ifdef IFU_EBREAK_HALT_EN
    chk("halt_flag", {31'd0, halted}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0800;
    req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_reqv", {31'd0, req_valid}, 32'd0);
      chk("halt_ov", {31'd0, out_valid}, 32'd0);
    end
    redirect_valid = 1'b0;
    req_ready = 1'b0;
    chk("halt_pc", req_addr, 32'h8000_0404);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_reqv", {31'd0, req_valid}, 32'd1);
    chk("halt_rst_addr", req_addr, 32'h8000_0000);
`else
    chk("ebk_halted", {31'd0, halted}, 32'd0);
    chk("ebk_reqv", {31'd0, req_valid}, 32'd1);
    chk("ebk_next", req_addr, 32'h8000_0404);
`endif

    // Reset in the middle of a fetch.
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("mrst_reqv", {31'd0, req_valid}, 32'd0);
    chk("mrst_addr", req_addr, 32'h8000_0000);
    chk("mrst_ov", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    tick();
    fetch("mrst", 32'h8000_0000, 32'h4444_4444, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
